// File: rtl/ysyx_22040125_halt_ctrl_pkg.sv
// ysyx_22040125_halt_ctrl_pkg: shared state encoding, constants and trace entry type for the halt controller
package ysyx_22040125_halt_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  localparam logic [11:0] BUBBLE_OP = 12'hfff;
  localparam logic [63:0] TIMEOUT_TRAP = 64'hffff_ffff_ffff_ffff;
  localparam int TRACE_DEPTH = 8;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } trace_ent_t;
endpackage

// File: rtl/ysyx_22040125_halt_ctrl_if.sv
// ysyx_22040125_halt_ctrl_if: pipeline-side bus of the halt controller (master = pipeline, slave = controller)
interface ysyx_22040125_halt_ctrl_if;
  logic        ebreak_in;
  logic [11:0] op_in;
  logic [31:0] inst_in;
  logic [63:0] pc_in;
  logic [63:0] a0_val;
  logic [2:0]  trace_idx;
  logic        stall_req;
  logic        halt;
  logic        halt_ok;
  logic        halt_timeout;
  logic [63:0] trap_code;
  logic [63:0] halt_pc;
  logic [63:0] retire_cnt;
  logic [63:0] cycle_cnt;
  logic [63:0] trace_pc;
  logic [31:0] trace_inst;
  modport master (
    output ebreak_in, op_in, inst_in, pc_in, a0_val, trace_idx,
    input  stall_req, halt, halt_ok, halt_timeout, trap_code, halt_pc, retire_cnt, cycle_cnt, trace_pc, trace_inst
  );
  modport slave (
    input  ebreak_in, op_in, inst_in, pc_in, a0_val, trace_idx,
    output stall_req, halt, halt_ok, halt_timeout, trap_code, halt_pc, retire_cnt, cycle_cnt, trace_pc, trace_inst
  );
endinterface

// File: rtl/ysyx_22040125_halt_trace.sv
// ysyx_22040125_halt_trace: 8-entry {pc, inst} ring of retired instructions, index 0 = most recent
module ysyx_22040125_halt_trace
  import ysyx_22040125_halt_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [63:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic [2:0]  i_idx,
  output logic [63:0] o_pc,
  output logic [31:0] o_inst
);
  trace_ent_t r_ring [TRACE_DEPTH];
  logic [2:0] r_wp;
  logic [2:0] w_rd;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TRACE_DEPTH; i++) r_ring[i] <= '0;
      r_wp <= '0;
    end else if (i_we) begin
      r_ring[r_wp] <= '{pc: i_pc, inst: i_inst};
      r_wp <= r_wp + 3'd1;
    end
  end
  assign w_rd = r_wp - 3'd1 - i_idx;
  assign o_pc = r_ring[w_rd].pc;
  assign o_inst = r_ring[w_rd].inst;
endmodule

// File: rtl/ysyx_22040125_halt_ctrl.sv
// ysyx_22040125_halt_ctrl: ebreak/watchdog halt FSM with retire and cycle counters; trace ring under YSYX_22040125_HALT_TRACE_EN
module ysyx_22040125_halt_ctrl
  import ysyx_22040125_halt_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input logic clk,
  input logic rst,
  ysyx_22040125_halt_ctrl_if.slave bus
);
  state_t r_state;
  logic [3:0] r_drain;
  logic [31:0] r_idle;
  logic [63:0] r_last_pc, r_retire, r_cycle, r_trap, r_hpc;
  logic r_stall, r_halt, r_ok, r_to;
  logic w_retire, w_ebreak, w_timeout;
  assign w_retire = r_state == RUN && bus.op_in != BUBBLE_OP;
  assign w_ebreak = w_retire && bus.ebreak_in;
  // fires in the idle cycle that would bring the idle count up to TIMEOUT
  assign w_timeout = TIMEOUT != 32'd0 && r_state == RUN && !w_retire && r_idle == TIMEOUT - 32'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_drain <= '0;
      r_idle <= '0;
      r_last_pc <= '0;
      r_retire <= '0;
      r_cycle <= '0;
      r_trap <= '0;
      r_hpc <= '0;
      r_stall <= 1'b0;
      r_halt <= 1'b0;
      r_ok <= 1'b0;
      r_to <= 1'b0;
    end else begin
      if (r_state != HALT) r_cycle <= r_cycle + 64'd1;
      if (r_state == RUN) r_idle <= w_retire ? 32'd0 : r_idle + 32'd1;
      if (w_retire) begin
        r_retire <= r_retire + 64'd1;
        r_last_pc <= bus.pc_in;
      end
      case (r_state)
        RUN:
          if (w_ebreak) begin
            r_state <= DRAIN;
            r_stall <= 1'b1;
            r_drain <= '0;
            r_hpc <= bus.pc_in;
          end else if (w_timeout) begin
            r_state <= HALT;
            r_stall <= 1'b1;
            r_halt <= 1'b1;
            r_to <= 1'b1;
            r_trap <= TIMEOUT_TRAP;
            r_hpc <= r_last_pc;
          end
        DRAIN:
          if (r_drain == 4'(DRAIN_CYCLES - 1)) begin
            r_state <= HALT;
            r_halt <= 1'b1;
            r_trap <= bus.a0_val;
            r_ok <= bus.a0_val == 64'd0;
          end else r_drain <= r_drain + 4'd1;
        default: ;
      endcase
    end
  end
  assign bus.stall_req = r_stall;
  assign bus.halt = r_halt;
  assign bus.halt_ok = r_ok;
  assign bus.halt_timeout = r_to;
  assign bus.trap_code = r_trap;
  assign bus.halt_pc = r_hpc;
  assign bus.retire_cnt = r_retire;
  assign bus.cycle_cnt = r_cycle;
`ifdef YSYX_22040125_HALT_TRACE_EN
  ysyx_22040125_halt_trace u_trace (
    .clk(clk),
    .rst(rst),
    .i_we(w_retire),
    .i_pc(bus.pc_in),
    .i_inst(bus.inst_in),
    .i_idx(bus.trace_idx),
    .o_pc(bus.trace_pc),
    .o_inst(bus.trace_inst)
  );
`else
  logic w_unused;
  assign w_unused = ^{bus.inst_in, bus.trace_idx};
  assign bus.trace_pc = '0;
  assign bus.trace_inst = '0;
`endif
endmodule

// File: tb/tb_ysyx_22040125_halt_ctrl.sv
// tb_ysyx_22040125_halt_ctrl: directed-vector bench for the halt controller (DRAIN_CYCLES=2, TIMEOUT=10)
module tb_ysyx_22040125_halt_ctrl;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  ysyx_22040125_halt_ctrl_if bif ();
  ysyx_22040125_halt_ctrl #(.DRAIN_CYCLES(2), .TIMEOUT(32'd10)) dut (.clk(clk), .rst(rst), .bus(bif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic eb, input logic [11:0] op, input logic [63:0] pc, input logic [63:0] a0);
    bif.ebreak_in = eb;
    bif.op_in = op;
    bif.pc_in = pc;
    bif.inst_in = pc[31:0] ^ 32'hA5A5_0000;
    bif.a0_val = a0;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc(1'b0, 12'hfff, 64'h0, 64'h0);
    rst = 1'b0;
  endtask
  initial begin
    bif.trace_idx = 3'd0;
    do_reset();
    chk("rst_stall", bif.stall_req, 0);
    chk("rst_halt", bif.halt, 0);
    chk("rst_retire", bif.retire_cnt, 0);
    chk("rst_cycle", bif.cycle_cnt, 0);
    chk("rst_trap", bif.trap_code, 0);
    chk("rst_hpc", bif.halt_pc, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 12'h013, 64'h8000_0000 + 64'(4 * i), 64'h0);
    chk("run_retire5", bif.retire_cnt, 5);
    chk("run_stall", bif.stall_req, 0);
    cyc(1'b1, 12'h073, 64'h8000_0014, 64'h0);
    chk("eb_stall1", bif.stall_req, 1);
    chk("eb_halt_d1", bif.halt, 0);
    chk("eb_retire", bif.retire_cnt, 6);
    cyc(1'b0, 12'hfff, 64'h0, 64'h0);
    chk("eb_stall2", bif.stall_req, 1);
    chk("eb_halt_d2", bif.halt, 0);
    cyc(1'b0, 12'hfff, 64'h0, 64'h0);
    chk("eb_halt", bif.halt, 1);
    chk("eb_ok", bif.halt_ok, 1);
    chk("eb_to", bif.halt_timeout, 0);
    chk("eb_hpc", bif.halt_pc, 64'h8000_0014);
    chk("eb_trap", bif.trap_code, 0);
    chk("eb_cycle", bif.cycle_cnt, 8);
    repeat (3) cyc(1'b1, 12'h013, 64'h9000_0000, 64'h7);
    chk("halt_hold", bif.halt, 1);
    chk("halt_retire_frozen", bif.retire_cnt, 6);
    chk("halt_cycle_frozen", bif.cycle_cnt, 8);
    chk("halt_hpc_frozen", bif.halt_pc, 64'h8000_0014);
    do_reset();
    cyc(1'b1, 12'h073, 64'h100, 64'h5);
    chk("eb1_retire", bif.retire_cnt, 1);
    cyc(1'b1, 12'h013, 64'h200, 64'h1);
    cyc(1'b1, 12'h013, 64'h200, 64'h1);
    chk("eb1_halt", bif.halt, 1);
    chk("eb1_ok", bif.halt_ok, 0);
    chk("eb1_trap", bif.trap_code, 1);
    chk("eb1_hpc", bif.halt_pc, 64'h100);
    chk("eb1_drain_frozen", bif.retire_cnt, 1);
    do_reset();
    repeat (3) cyc(1'b1, 12'hfff, 64'h50, 64'h0);
    chk("bub_stall", bif.stall_req, 0);
    chk("bub_retire", bif.retire_cnt, 0);
    cyc(1'b0, 12'h013, 64'h300, 64'h0);
    repeat (9) cyc(1'b0, 12'hfff, 64'h0, 64'h0);
    chk("wd_halt9", bif.halt, 0);
    cyc(1'b0, 12'hfff, 64'h0, 64'h0);
    chk("wd_halt", bif.halt, 1);
    chk("wd_to", bif.halt_timeout, 1);
    chk("wd_ok", bif.halt_ok, 0);
    chk("wd_stall", bif.stall_req, 1);
    chk("wd_trap", bif.trap_code, 64'hffff_ffff_ffff_ffff);
    chk("wd_hpc", bif.halt_pc, 64'h300);
    chk("wd_cycle", bif.cycle_cnt, 14);
    do_reset();
    repeat (9) cyc(1'b0, 12'hfff, 64'h0, 64'h0);
    cyc(1'b1, 12'h073, 64'h400, 64'h0);
    chk("race_stall", bif.stall_req, 1);
    chk("race_halt", bif.halt, 0);
    chk("race_to", bif.halt_timeout, 0);
    repeat (2) cyc(1'b0, 12'hfff, 64'h0, 64'h0);
    chk("race_halt2", bif.halt, 1);
    chk("race_to2", bif.halt_timeout, 0);
    chk("race_hpc", bif.halt_pc, 64'h400);
    do_reset();
    cyc(1'b1, 12'h073, 64'h500, 64'h3);
    rst = 1'b1;
    cyc(1'b0, 12'hfff, 64'h0, 64'h3);
    rst = 1'b0;
    chk("mrst_stall", bif.stall_req, 0);
    chk("mrst_retire", bif.retire_cnt, 0);
    chk("mrst_hpc", bif.halt_pc, 0);
    chk("mrst_cycle", bif.cycle_cnt, 0);
    repeat (3) cyc(1'b0, 12'hfff, 64'h0, 64'h3);
    chk("mrst_halt", bif.halt, 0);
    chk("mrst_run_stall", bif.stall_req, 0);
    chk("mrst_run_cycle", bif.cycle_cnt, 3);
    do_reset();
    for (int i = 1; i <= 10; i++) cyc(1'b0, 12'h013, 64'h1000 + 64'(4 * i), 64'h0);
    bif.trace_idx = 3'd0;
    #1;
`ifdef YSYX_22040125_HALT_TRACE_EN
    chk("tr0_pc", bif.trace_pc, 64'h1028);
    chk("tr0_inst", {32'h0, bif.trace_inst}, 64'hA5A5_1028);
    bif.trace_idx = 3'd7;
    #1;
    chk("tr7_pc", bif.trace_pc, 64'h100c);
    chk("tr7_inst", {32'h0, bif.trace_inst}, 64'hA5A5_100C);
`else
    chk("tr_off_pc", bif.trace_pc, 0);
    chk("tr_off_inst", {32'h0, bif.trace_inst}, 0);
`endif
    chk("tr_retire", bif.retire_cnt, 10);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22040125_halt_ctrl.md
YSYX_22040125_HALT_CTRL -- requirements
Module: ysyx_22040125_halt_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2: cycles held in DRAIN before a0 is sampled; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 32'd1_000_000: idle cycles with no retire before a watchdog halt; 0 disables the watchdog.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ebreak_in  in  1  delayed ebreak flag from the EBREAK delay stage.
REQ-006 op_in  in  12  delayed opcode class; 12'hfff marks a bubble.
REQ-007 inst_in  in  32  delayed instruction word.
REQ-008 pc_in  in  64  PC of the instruction on op_in.
REQ-009 a0_val  in  64  architectural x10 value after write-back.
REQ-010 stall_req  out  1  pipeline freeze request.
REQ-011 halt  out  1  sticky halt indication.
REQ-012 halt_ok  out  1  high when halted by ebreak with a0 == 0.
REQ-013 halt_timeout  out  1  high when halted by the watchdog.
REQ-014 trap_code  out  64  a0 value sampled at halt.
REQ-015 halt_pc  out  64  PC of the halting ebreak.
REQ-016 retire_cnt  out  64  count of retired instructions.
REQ-017 cycle_cnt  out  64  count of cycles since reset.
REQ-018 trace_idx  in  3  trace read index (see REQ-036).
REQ-019 trace_pc / trace_inst  out  64 / 32  trace read data.

Function
REQ-020 A retire event SHALL be any cycle with op_in != 12'hfff while state is RUN.
REQ-021 FSM states SHALL be RUN, DRAIN and HALT.
REQ-022 RUN -> DRAIN SHALL occur on a retire event with ebreak_in = 1; halt_pc SHALL capture pc_in in that cycle.
REQ-023 ebreak_in SHALL be ignored when op_in = 12'hfff, and in DRAIN and HALT.
REQ-024 DRAIN SHALL last exactly DRAIN_CYCLES cycles, with stall_req = 1 throughout.
REQ-025 On DRAIN exit: state -> HALT; trap_code <= a0_val; halt_ok <= (a0_val == 0).
REQ-026 HALT SHALL be absorbing until rst; halt = 1 and stall_req = 1 in HALT.
REQ-027 retire_cnt SHALL increment by 1 per retire event, including the ebreak itself; it SHALL be frozen in DRAIN and HALT.
REQ-028 cycle_cnt SHALL increment every cycle in RUN and DRAIN, freeze in HALT, and wrap modulo 2^64.
REQ-029 Watchdog: a 32-bit idle counter SHALL reset on a retire event and otherwise increment in RUN.
REQ-030 On reaching TIMEOUT, the FSM SHALL go RUN -> HALT directly: halt_timeout = 1, halt_ok = 0, trap_code = 64'hffff_ffff_ffff_ffff, halt_pc = last retired PC.
REQ-031 If an ebreak retire event and the timeout occur in the same cycle, ebreak SHALL win and no timeout is recorded.
REQ-032 halt, halt_ok and halt_timeout SHALL change only on entry to HALT.

Reset
REQ-033 rst SHALL, with priority over every event including mid-DRAIN, set: state RUN, all counters 0, idle counter 0, halt/halt_ok/halt_timeout/stall_req 0, trap_code/halt_pc 0, trace storage 0.

Configuration
REQ-034 Macro YSYX_22040125_HALT_TRACE_EN SHALL compile in the trace buffer.
REQ-035 With the macro: an 8-entry ring of {pc, inst} SHALL be written on each retire event; the write pointer wraps 7 -> 0.
REQ-036 With the macro: trace_idx = 0 SHALL read the most recent entry and trace_idx = k the k-th older entry, combinationally.
REQ-037 Without the macro: trace_pc and trace_inst SHALL be tied to 0 and no storage SHALL be inferred.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding, the BUBBLE_OP = 12'hfff constant and the TIMEOUT trap-code constant.
REQ-039 The trace ring SHALL be a sub-module, ysyx_22040125_halt_trace, instantiated only under the macro.

Verification
REQ-040 Retire 5 non-bubble ops, then ebreak at pc 0x8000_0014 with a0 = 0 -> stall_req high 2 cycles, then halt = 1, halt_ok = 1, retire_cnt = 6, halt_pc = 0x8000_0014.
REQ-041 ebreak with a0 = 1 -> halt = 1, halt_ok = 0, trap_code = 1.
REQ-042 ebreak_in = 1 with op_in = 12'hfff -> no state change; retire_cnt unchanged.
REQ-043 TIMEOUT = 10, bubbles only -> halt_timeout = 1 after 10 idle cycles; ebreak on the 10th idle cycle -> DRAIN, halt_timeout = 0.
REQ-044 rst asserted during DRAIN -> next cycle state RUN, all outputs 0.
REQ-045 With the macro, retire 10 instructions -> trace_idx = 0 returns the 10th and trace_idx = 7 returns the 3rd.
